seq_ctrl_team1: RTL and testbench

Timing and control generator for the single-purpose processor. It produces the one-hot timing vector T[15:0] and the decoded-opcode vector D[7:0] that the register control decoders consume; the DR control, for example, uses T[4], T[5], D[0], D[1], D[2] and D[6]. Internally it holds a sequence counter (SC) and a run flag, and it latches the opcode and indirect bit from the instruction register. It sits between the IR and every register-control block.

---
 rtl/seq_ctrl_team1_pkg.sv | 18 +
 rtl/seq_ctrl_team1_if.sv | 21 ++
 rtl/onehot_dec_team1.sv | 13 +
 rtl/seq_ctrl_team1.sv | 77 +++++++
 tb/tb_seq_ctrl_team1.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/seq_ctrl_team1_pkg.sv
// Shared constants and state type for the sequence/timing controller.
package seq_pkg_team1;
  localparam int SC_WIDTH = 4;
  localparam int OP_WIDTH = 3;
  localparam int T_W      = 1 << SC_WIDTH;
  localparam int D_W      = 1 << OP_WIDTH;
  localparam int T_DECODE = 2;
  localparam int SC_MAX   = 15;
  localparam int OP_MSB   = 14;
  localparam int OP_LSB   = 12;
  localparam int I_BIT    = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2
  } seq_state_e;
endpackage

// File: rtl/seq_ctrl_team1_if.sv
// Control-side bundle between the IR/control logic and the sequence controller.
// No handshake: START/HLT/CLR_SC are levels sampled on every rising edge; T/D/I/SC/RUN/TIMEOUT are always valid.
interface seq_ctrl_team1_if;
  import seq_pkg_team1::*;
  logic                START;
  logic                HLT;
  logic                CLR_SC;
  logic [15:0]         in_IR;
  logic [T_W-1:0]      T;
  logic [D_W-1:0]      D;
  logic                I;
  logic [SC_WIDTH-1:0] SC;
  logic                RUN;
  logic                TIMEOUT;
  seq_state_e          state;

  modport master (output START, HLT, CLR_SC, in_IR,
                  input  T, D, I, SC, RUN, TIMEOUT, state);
  modport slave  (input  START, HLT, CLR_SC, in_IR,
                  output T, D, I, SC, RUN, TIMEOUT, state);
endinterface

// File: rtl/onehot_dec_team1.sv
// Combinational binary-to-one-hot decoder; output is all-zero when en is low.
module onehot_dec_team1 #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      sel,
  input  logic                 en,
  output logic [(1<<IN_W)-1:0] y
);
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end
endmodule

// File: rtl/seq_ctrl_team1.sv
// Timing (T) and decoded-opcode (D) generator for the processor control path.
// Define SEQ_TIMEOUT_EN to stop with a sticky TIMEOUT on SC overrun instead of wrapping.
module seq_ctrl_team1
  import seq_pkg_team1::*;
(
  input  logic              clk,
  input  logic              CLR_GLOBAL,
  seq_ctrl_team1_if.slave   bus
);
  seq_state_e          state_q;
  logic [SC_WIDTH-1:0] sc_q;
  logic [D_W-1:0]      d_q;
  logic                i_q;
  logic [D_W-1:0]      op_onehot;
  logic                run;
  logic                unused_ir;

  assign run       = (state_q == ST_RUN);
  assign unused_ir = ^bus.in_IR[OP_LSB-1:0];

  onehot_dec_team1 #(.IN_W(SC_WIDTH)) u_t_dec (
    .sel (sc_q),
    .en  (run),
    .y   (bus.T)
  );

  onehot_dec_team1 #(.IN_W(OP_WIDTH)) u_op_dec (
    .sel (bus.in_IR[OP_MSB:OP_LSB]),
    .en  (1'b1),
    .y   (op_onehot)
  );

  // Priority: reset > halt > end-of-instruction > start > step.
  always_ff @(posedge clk) begin
    if (CLR_GLOBAL) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      d_q     <= '0;
      i_q     <= 1'b0;
    end else if (bus.HLT) begin
      sc_q <= '0;
      if (state_q == ST_RUN) state_q <= ST_IDLE;
    end else if (bus.CLR_SC && run) begin
      sc_q <= '0;
      d_q  <= '0;
    end else if (bus.START && state_q == ST_IDLE) begin
      state_q <= ST_RUN;
      sc_q    <= '0;
    end else if (run) begin
      if (sc_q == SC_WIDTH'(T_DECODE)) begin
        d_q <= op_onehot;
        i_q <= bus.in_IR[I_BIT];
      end
`ifdef SEQ_TIMEOUT_EN
      if (sc_q == SC_WIDTH'(SC_MAX)) begin
        state_q <= ST_TIMEOUT;
        sc_q    <= '0;
      end else begin
        sc_q <= sc_q + 1'b1;
      end
`else
      sc_q <= sc_q + 1'b1;
`endif
    end
  end

  assign bus.D     = d_q;
  assign bus.I     = i_q;
  assign bus.SC    = sc_q;
  assign bus.RUN   = run;
  assign bus.state = state_q;
`ifdef SEQ_TIMEOUT_EN
  assign bus.TIMEOUT = (state_q == ST_TIMEOUT);
`else
  assign bus.TIMEOUT = 1'b0;
`endif
endmodule

// File: tb/tb_seq_ctrl_team1.sv
// Scoreboard bench for seq_ctrl_team1: directed plan followed by random control traffic.
module tb_seq_ctrl_team1;
  localparam int EXP_W = 31;

  logic clk;
  logic CLR_GLOBAL;
  seq_ctrl_team1_if bus ();

  seq_ctrl_team1 dut (
    .clk        (clk),
    .CLR_GLOBAL (CLR_GLOBAL),
    .bus        (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];

  // behavioural model state
  bit m_run = 0;
  bit m_to  = 0;
  int m_sc  = 0;
  int m_op  = -1;
  bit m_i   = 0;

  function automatic logic [EXP_W-1:0] model_outputs();
    logic [15:0] t;
    logic [7:0]  d;
    t = m_run ? (16'h1 << m_sc) : 16'h0;
    d = (m_op < 0) ? 8'h0 : (8'h1 << m_op);
    return {t, d, m_i, 4'(m_sc), m_run, m_to};
  endfunction

  // driver: apply one edge's inputs, advance the model, queue the expected result
  task automatic drive(input bit rst, input bit start, input bit hlt,
                       input bit clr_sc, input logic [15:0] ir);
    @(negedge clk);
    CLR_GLOBAL = rst;
    bus.START  = start;
    bus.HLT    = hlt;
    bus.CLR_SC = clr_sc;
    bus.in_IR  = ir;
    if (rst) begin
      m_run = 0; m_to = 0; m_sc = 0; m_op = -1; m_i = 0;
    end else if (hlt) begin
      m_run = 0; m_sc = 0;
    end else if (clr_sc && m_run) begin
      m_sc = 0; m_op = -1;
    end else if (start && !m_run && !m_to) begin
      m_run = 1; m_sc = 0;
    end else if (m_run) begin
      if (m_sc == 2) begin
        m_op = int'(ir[14:12]);
        m_i  = ir[15];
      end
      if (m_sc == 15) begin
`ifdef SEQ_TIMEOUT_EN
        m_to = 1; m_run = 0; m_sc = 0;
`else
        m_sc = 0;
`endif
      end else begin
        m_sc = m_sc + 1;
      end
    end
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n, input logic [15:0] ir);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, ir);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // monitor: pops one expected entry per edge and compares every output
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("T",       bus.T,                e[30:15]);
        cmp("D",       16'(bus.D),           16'(e[14:7]));
        cmp("I",       16'(bus.I),           16'(e[6]));
        cmp("SC",      16'(bus.SC),          16'(e[5:2]));
        cmp("RUN",     16'(bus.RUN),         16'(e[1]));
        cmp("TIMEOUT", 16'(bus.TIMEOUT),     16'(e[0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ir;
    bit r, s, h, c;
    CLR_GLOBAL = 1'b1;
    bus.START  = 1'b0;
    bus.HLT    = 1'b0;
    bus.CLR_SC = 1'b0;
    bus.in_IR  = 16'h0;

    // reset then idle
    drive(1, 0, 0, 0, 16'h0);
    idle(5, 16'h0);

    // fetch/decode with E123, end of instruction at T5
    drive(0, 1, 0, 0, 16'hE123);
    idle(5, 16'hE123);
    drive(0, 0, 0, 1, 16'h2000);
    idle(3, 16'h2000);
    // halt during T3, restart, start+halt together
    drive(0, 0, 1, 0, 16'h2000);
    idle(2, 16'h2000);
    drive(0, 1, 0, 0, 16'h2000);
    drive(0, 1, 1, 0, 16'h2000);
    idle(2, 16'h2000);
    // CLR_SC coinciding with the latch step
    drive(0, 1, 0, 0, 16'h5000);
    idle(2, 16'h5000);
    drive(0, 0, 0, 1, 16'h5000);
    idle(2, 16'h7000);
    // reset together with start
    drive(1, 1, 0, 0, 16'h7000);
    idle(1, 16'h7000);
    // overrun: no CLR_SC for more than 16 steps, then a START attempt
    drive(0, 1, 0, 0, 16'hB000);
    idle(20, 16'hB000);
    drive(0, 1, 0, 0, 16'hB000);
    idle(3, 16'hB000);
    drive(1, 0, 0, 0, 16'h0);

    // random control traffic
    for (int n = 0; n < 3000; n++) begin
      ir = 16'($urandom);
      r  = ($urandom_range(0, 63) == 0);
      h  = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 3) == 0);
      drive(r, s, h, c, ir);
    end

    idle(2, 16'h0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
